// File: rtl/scalar_register_file_mp_if.sv
// Issue / read / write-back bundle for the scalar register file.
// The master side is the pipeline; the slave side is the register file.
interface scalar_register_file_mp_if #(
   parameter int LEN    = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
);
   logic                     rdy_in;
   logic [NUM_RD*ADDR_W-1:0] rd_idx;
   logic [NUM_RD*LEN-1:0]    rd_data;
   logic [NUM_RD-1:0]        rd_ready;
   logic                     alloc_en;
   logic [ADDR_W-1:0]        alloc_idx;
   logic                     alloc_ok;
   logic [NUM_WR-1:0]        wb_en;
   logic [NUM_WR*ADDR_W-1:0] wb_idx;
   logic [NUM_WR*LEN-1:0]    wb_data;
   logic                     flush;
   logic [ADDR_W:0]          busy_cnt;
   logic [1:0]               rf_status;

   modport master (
      output rdy_in, rd_idx, alloc_en, alloc_idx,
      output wb_en, wb_idx, wb_data, flush,
      input  rd_data, rd_ready, alloc_ok, busy_cnt, rf_status
   );

   modport slave (
      input  rdy_in, rd_idx, alloc_en, alloc_idx,
      input  wb_en, wb_idx, wb_data, flush,
      output rd_data, rd_ready, alloc_ok, busy_cnt, rf_status
   );
endinterface

// File: rtl/scalar_register_file_mp.sv
// Multi-ported scalar register file with busy-bit scoreboard
// and same-cycle write-back to read bypass.
module scalar_register_file_mp #(
   parameter int LEN     = 32,
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter int NUM_WR  = 2,
   parameter bit BYPASS  = 1'b1
) (
   input logic clk,
   input logic rst,
   scalar_register_file_mp_if.slave bus
);
   localparam logic [1:0] RF_NOP      = 2'd0;
   localparam logic [1:0] RF_FINISHED = 2'd1;
   localparam int DEPTH = 1 << ADDR_W;
   // Bit i set when index i names a real register.
   localparam logic [DEPTH-1:0] IDX_OK =
      {DEPTH{1'b1}} >> (DEPTH - REG_NUM);

   logic [LEN-1:0]     regs_q [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;
   logic [ADDR_W:0]    cnt_q, cnt_d;
   logic [1:0]         status_q, status_d;

   logic [REG_NUM-1:0] hit;
   logic [LEN-1:0]     wval [REG_NUM];
   logic               alloc_rel, alloc_busy, alloc_ok;
   logic [ADDR_W-1:0]  wi, ri;
   logic               byp;
   logic [NUM_RD*LEN-1:0] rdat;
   logic [NUM_RD-1:0]     rrdy;

   // Higher write ports overwrite lower ones on the same index.
   always_comb begin
      hit = '0;
      wi  = '0;
      for (int i = 0; i < REG_NUM; i++) wval[i] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
         wi = bus.wb_idx[w*ADDR_W +: ADDR_W];
         if (bus.wb_en[w] && wi != '0 && IDX_OK[wi]) begin
            hit[wi]  = 1'b1;
            wval[wi] = bus.wb_data[w*LEN +: LEN];
         end
      end
   end

   always_comb begin
      alloc_rel = 1'b0;
      for (int w = 0; w < NUM_WR; w++)
         if (bus.wb_en[w] &&
             bus.wb_idx[w*ADDR_W +: ADDR_W] == bus.alloc_idx)
            alloc_rel = 1'b1;
      alloc_busy = IDX_OK[bus.alloc_idx] && busy_q[bus.alloc_idx];
      alloc_ok = rst && bus.rdy_in && bus.alloc_en && !bus.flush &&
                 (!alloc_busy || alloc_rel);
   end

   // A new reservation outranks a same-cycle release.
   always_comb begin
      busy_d = busy_q & ~hit;
      if (alloc_ok && bus.alloc_idx != '0 && IDX_OK[bus.alloc_idx])
         busy_d[bus.alloc_idx] = 1'b1;
      if (bus.flush) busy_d = '0;
      cnt_d    = (ADDR_W+1)'($countones(busy_d));
      status_d = (|bus.wb_en) ? RF_FINISHED : RF_NOP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
         busy_q   <= '0;
         cnt_q    <= '0;
         status_q <= RF_NOP;
      end else if (bus.rdy_in) begin
         for (int i = 0; i < REG_NUM; i++)
            if (hit[i]) regs_q[i] <= wval[i];
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
      end
   end

   always_comb begin
      rdat = '0;
      rrdy = '1;
      ri   = '0;
      byp  = 1'b0;
      for (int p = 0; p < NUM_RD; p++) begin
         ri  = bus.rd_idx[p*ADDR_W +: ADDR_W];
         byp = 1'b0;
         if (rst && ri != '0 && IDX_OK[ri]) begin
            if (BYPASS && bus.rdy_in)
               for (int w = 0; w < NUM_WR; w++)
                  if (bus.wb_en[w] &&
                      bus.wb_idx[w*ADDR_W +: ADDR_W] == ri) begin
                     byp = 1'b1;
                     rdat[p*LEN +: LEN] = bus.wb_data[w*LEN +: LEN];
                  end
            if (!byp) begin
               rdat[p*LEN +: LEN] = regs_q[ri];
               rrdy[p] = !busy_q[ri];
            end
         end
      end
   end

   assign bus.rd_data   = rdat;
   assign bus.rd_ready  = rrdy;
   assign bus.alloc_ok  = alloc_ok;
   assign bus.busy_cnt  = cnt_q;
   assign bus.rf_status = status_q;
endmodule

// File: tb/tb_scalar_register_file_mp.sv
// Directed bench for scalar_register_file_mp: reset, alloc/wb,
// bypass, WAW stall, flush and freeze scenarios.
module tb_scalar_register_file_mp;
   localparam logic [1:0] NOP = 2'd0;
   localparam logic [1:0] FIN = 2'd1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int total = 0;
   int bad = 0;

   scalar_register_file_mp_if #(.LEN(32), .ADDR_W(5),
      .NUM_RD(2), .NUM_WR(2)) rf_if ();

   scalar_register_file_mp #(.LEN(32), .REG_NUM(32), .ADDR_W(5),
      .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .bus(rf_if));

   always #5 clk = ~clk;

   task automatic idle();
      rf_if.rdy_in    = 1'b1;
      rf_if.rd_idx    = '0;
      rf_if.alloc_en  = 1'b0;
      rf_if.alloc_idx = '0;
      rf_if.wb_en     = '0;
      rf_if.wb_idx    = '0;
      rf_if.wb_data   = '0;
      rf_if.flush     = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      idle();
      rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'd6;
      rf_if.wb_en = 2'b01; rf_if.wb_idx = {5'd0, 5'd2};
      rf_if.wb_data = {32'd0, 32'h55};
      @(negedge clk);
      total++;
      if (rf_if.busy_cnt !== 6'd1) begin
         bad++; $display("FAIL pre_cnt got=%0d exp=1", rf_if.busy_cnt);
      end
      total++;
      if (rf_if.rf_status !== FIN) begin
         bad++; $display("FAIL pre_status got=%0d exp=%0d", rf_if.rf_status, FIN);
      end
      rf_if.rd_idx = {5'd6, 5'd2};
      #2 rst = 1'b0;
      #1;
      total++;
      if (rf_if.rd_data !== 64'd0) begin
         bad++; $display("FAIL rst_data got=%h exp=0", rf_if.rd_data);
      end
      total++;
      if (rf_if.rd_ready !== 2'b11) begin
         bad++; $display("FAIL rst_ready got=%b exp=11", rf_if.rd_ready);
      end
      total++;
      if (rf_if.alloc_ok !== 1'b0) begin
         bad++; $display("FAIL rst_alloc got=%b exp=0", rf_if.alloc_ok);
      end
      total++;
      if (rf_if.busy_cnt !== 6'd0 || rf_if.rf_status !== NOP) begin
         bad++; $display("FAIL rst_state cnt=%0d st=%0d exp 0/0",
            rf_if.busy_cnt, rf_if.rf_status);
      end
      @(negedge clk);
      rst = 1'b1;
      idle();
      rf_if.rd_idx = {5'd6, 5'd2};
      #1;
      total++;
      if (rf_if.rd_data !== 64'd0 || rf_if.rd_ready !== 2'b11) begin
         bad++; $display("FAIL rst_regs got=%h/%b exp=0/11",
            rf_if.rd_data, rf_if.rd_ready);
      end
   endtask

   task automatic test_alloc_wb();
      @(negedge clk);
      idle();
      rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'd5;
      #1;
      total++;
      if (rf_if.alloc_ok !== 1'b1) begin
         bad++; $display("FAIL alloc5_ok got=%b exp=1", rf_if.alloc_ok);
      end
      @(negedge clk);
      idle();
      rf_if.rd_idx = {5'd0, 5'd5};
      #1;
      total++;
      if (rf_if.rd_ready[0] !== 1'b0 || rf_if.busy_cnt !== 6'd1) begin
         bad++; $display("FAIL x5_pending rdy=%b cnt=%0d exp 0/1",
            rf_if.rd_ready[0], rf_if.busy_cnt);
      end
      rf_if.wb_en = 2'b01; rf_if.wb_idx = {5'd0, 5'd5};
      rf_if.wb_data = {32'd0, 32'hDEADBEEF};
      #1;
      total++;
      if (rf_if.rd_data[31:0] !== 32'hDEADBEEF || rf_if.rd_ready[0] !== 1'b1) begin
         bad++; $display("FAIL x5_bypass got=%h/%b exp=deadbeef/1",
            rf_if.rd_data[31:0], rf_if.rd_ready[0]);
      end
      @(negedge clk);
      idle();
      rf_if.rd_idx = {5'd5, 5'd0};
      #1;
      total++;
      if (rf_if.busy_cnt !== 6'd0 || rf_if.rf_status !== FIN) begin
         bad++; $display("FAIL x5_commit cnt=%0d st=%0d exp 0/1",
            rf_if.busy_cnt, rf_if.rf_status);
      end
      total++;
      if (rf_if.rd_data[63:32] !== 32'hDEADBEEF || rf_if.rd_ready !== 2'b11) begin
         bad++; $display("FAIL x5_read got=%h/%b exp=deadbeef/11",
            rf_if.rd_data[63:32], rf_if.rd_ready);
      end
   endtask

   task automatic test_multi_wb();
      @(negedge clk);
      idle();
      rf_if.wb_en = 2'b11; rf_if.wb_idx = {5'd7, 5'd7};
      rf_if.wb_data = {32'h22, 32'h11};
      rf_if.rd_idx = {5'd7, 5'd0};
      #1;
      total++;
      if (rf_if.rd_data[63:32] !== 32'h22) begin
         bad++; $display("FAIL x7_bypass got=%h exp=22", rf_if.rd_data[63:32]);
      end
      @(negedge clk);
      idle();
      rf_if.rd_idx = {5'd0, 5'd7};
      #1;
      total++;
      if (rf_if.rd_data[31:0] !== 32'h22) begin
         bad++; $display("FAIL x7_reg got=%h exp=22", rf_if.rd_data[31:0]);
      end
   endtask

   task automatic test_waw();
      @(negedge clk);
      idle();
      rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'd3;
      @(negedge clk);
      #1;
      total++;
      if (rf_if.alloc_ok !== 1'b0) begin
         bad++; $display("FAIL waw_stall got=%b exp=0", rf_if.alloc_ok);
      end
      @(negedge clk);
      total++;
      if (rf_if.busy_cnt !== 6'd1) begin
         bad++; $display("FAIL waw_cnt got=%0d exp=1", rf_if.busy_cnt);
      end
      rf_if.wb_en = 2'b10; rf_if.wb_idx = {5'd3, 5'd0};
      rf_if.wb_data = {32'hABC, 32'd0};
      #1;
      total++;
      if (rf_if.alloc_ok !== 1'b1) begin
         bad++; $display("FAIL waw_release got=%b exp=1", rf_if.alloc_ok);
      end
      @(negedge clk);
      idle();
      rf_if.rd_idx = {5'd0, 5'd3};
      #1;
      total++;
      if (rf_if.busy_cnt !== 6'd1 || rf_if.rd_ready[0] !== 1'b0 ||
          rf_if.rd_data[31:0] !== 32'hABC) begin
         bad++; $display("FAIL waw_after cnt=%0d rdy=%b d=%h exp 1/0/abc",
            rf_if.busy_cnt, rf_if.rd_ready[0], rf_if.rd_data[31:0]);
      end
      rf_if.wb_en = 2'b01; rf_if.wb_idx = {5'd0, 5'd3};
      rf_if.wb_data = {32'd0, 32'hABD};
      @(negedge clk);
      idle();
      total++;
      if (rf_if.busy_cnt !== 6'd0) begin
         bad++; $display("FAIL waw_clear got=%0d exp=0", rf_if.busy_cnt);
      end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         idle();
         rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'(i);
      end
      @(negedge clk);
      idle();
      total++;
      if (rf_if.busy_cnt !== 6'd3) begin
         bad++; $display("FAIL fl_pre got=%0d exp=3", rf_if.busy_cnt);
      end
      rf_if.flush = 1'b1;
      rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'd4;
      rf_if.wb_en = 2'b01; rf_if.wb_idx = {5'd0, 5'd9};
      rf_if.wb_data = {32'd0, 32'd5};
      #1;
      total++;
      if (rf_if.alloc_ok !== 1'b0) begin
         bad++; $display("FAIL fl_alloc got=%b exp=0", rf_if.alloc_ok);
      end
      @(negedge clk);
      idle();
      rf_if.rd_idx = {5'd4, 5'd9};
      #1;
      total++;
      if (rf_if.busy_cnt !== 6'd0) begin
         bad++; $display("FAIL fl_cnt got=%0d exp=0", rf_if.busy_cnt);
      end
      total++;
      if (rf_if.rd_data[31:0] !== 32'd5 || rf_if.rd_ready !== 2'b11) begin
         bad++; $display("FAIL fl_x9 got=%h/%b exp=5/11",
            rf_if.rd_data[31:0], rf_if.rd_ready);
      end
   endtask

   task automatic test_freeze();
      @(negedge clk);
      idle();
      @(negedge clk);
      rf_if.rdy_in = 1'b0;
      rf_if.wb_en = 2'b01; rf_if.wb_idx = {5'd0, 5'd4};
      rf_if.wb_data = {32'd0, 32'd9};
      rf_if.alloc_en = 1'b1; rf_if.alloc_idx = 5'd6;
      rf_if.rd_idx = {5'd6, 5'd4};
      #1;
      total++;
      if (rf_if.alloc_ok !== 1'b0 || rf_if.rd_data[31:0] !== 32'd0) begin
         bad++; $display("FAIL frz_comb ok=%b d=%h exp 0/0",
            rf_if.alloc_ok, rf_if.rd_data[31:0]);
      end
      @(negedge clk);
      #1;
      total++;
      if (rf_if.rd_data !== 64'd0 || rf_if.rd_ready !== 2'b11) begin
         bad++; $display("FAIL frz_regs got=%h/%b exp=0/11",
            rf_if.rd_data, rf_if.rd_ready);
      end
      total++;
      if (rf_if.busy_cnt !== 6'd0 || rf_if.rf_status !== NOP) begin
         bad++; $display("FAIL frz_state cnt=%0d st=%0d exp 0/0",
            rf_if.busy_cnt, rf_if.rf_status);
      end
      idle();
      rf_if.wb_en = 2'b10; rf_if.wb_idx = {5'd0, 5'd0};
      rf_if.wb_data = {32'hFF, 32'd0};
      #1;
      total++;
      if (rf_if.rd_data[31:0] !== 32'd0 || rf_if.rd_ready[0] !== 1'b1) begin
         bad++; $display("FAIL x0_bypass got=%h/%b exp=0/1",
            rf_if.rd_data[31:0], rf_if.rd_ready[0]);
      end
      @(negedge clk);
      idle();
      #1;
      total++;
      if (rf_if.rd_data[31:0] !== 32'd0 || rf_if.rf_status !== FIN) begin
         bad++; $display("FAIL x0_reg d=%h st=%0d exp 0/1",
            rf_if.rd_data[31:0], rf_if.rf_status);
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc_wb();
      test_multi_wb();
      test_waw();
      test_flush();
      test_freeze();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
